// File: rtl/banner_sprite.sv
// Scaled, animated, blinking sprite overlay: raster position -> image ROM -> palette ROM -> RGB,
// with a fixed 5-cycle pixel pipeline and all placement/mode inputs shadowed at frame_tick_in.
module banner_sprite #(
    parameter int WIDTH           = 73,
    parameter int HEIGHT          = 9,
    parameter int NUM_FRAMES      = 4,
    parameter int SCALE_LOG2      = 2,
    parameter int FRAME_HOLD      = 8,
    parameter int BLINK_PERIOD    = 30,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    input  logic [10:0] x_in,
    input  logic [9:0]  y_in,
    input  logic        frame_tick_in,
    input  logic        show_in,
    input  logic        blink_en_in,
    input  logic        anim_en_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        opaque_out,
    output logic [1:0]  state_out      // debug: 0 HIDDEN, 1 SOLID, 2 BLINK_ON, 3 BLINK_OFF
);
    localparam int BOX_W    = WIDTH << SCALE_LOG2;
    localparam int BOX_H    = HEIGHT << SCALE_LOG2;
    localparam int FRAME_SZ = WIDTH * HEIGHT;
    localparam int AW       = $clog2(NUM_FRAMES * FRAME_SZ);
    localparam int FW       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int HW       = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
    localparam int BW       = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

    typedef enum logic [1:0] {HIDDEN, SOLID, BLINK_ON, BLINK_OFF} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [10:0]     x_q;
    logic [9:0]      y_q;
    logic            show_q, blink_q, anim_q;

    logic [11:0]     h12, v12, x12, y12, dh, dv;
    logic            in_box, qual_d;
    logic [AW-1:0]   addr_d, addr_q;
    logic [3:0]      qual_q;
    logic [7:0]      idx_a_q, idx_q, idx_p_q;
    logic [23:0]     rgb_a_q;

    // Procedurally generated image content: palette index is the low byte of the address.
    function automatic logic [7:0] image_rom(input logic [AW-1:0] a);
        return 8'(a);
    endfunction

    function automatic logic [23:0] palette_rom(input logic [7:0] i);
        return {i, ~i, i[3:0], i[7:4]};
    endfunction

    assign state_out = state_q;

    // Mode decisions on a tick use the values being latched on that same tick.
    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        frame_d     = frame_q;
        hold_d      = hold_q;
        if (frame_tick_in) begin
            if (!show_in) begin
                state_d = HIDDEN;
            end else if (!blink_en_in) begin
                state_d = SOLID;
            end else if (state_q == HIDDEN || state_q == SOLID) begin
                state_d     = BLINK_ON;
                blink_cnt_d = '0;
            end else if (blink_cnt_q == BW'(BLINK_PERIOD - 1)) begin
                state_d     = (state_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end

            if (state_d == HIDDEN && state_q != HIDDEN) begin
                frame_d = '0;
                hold_d  = '0;
            end else if (anim_en_in) begin
                if (hold_q == HW'(FRAME_HOLD - 1)) begin
                    hold_d  = '0;
                    frame_d = (frame_q == FW'(NUM_FRAMES - 1)) ? '0 : frame_q + FW'(1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
    end

    always_comb begin
        h12    = {1'b0, hcount_in};
        v12    = {2'b0, vcount_in};
        x12    = {1'b0, x_q};
        y12    = {2'b0, y_q};
        dh     = h12 - x12;
        dv     = v12 - y12;
        in_box = (h12 >= x12) && (h12 < x12 + 12'(BOX_W)) &&
                 (v12 >= y12) && (v12 < y12 + 12'(BOX_H));
        addr_d = AW'(32'(frame_q) * 32'(FRAME_SZ) +
                     32'(dv >> SCALE_LOG2) * 32'(WIDTH) +
                     32'(dh >> SCALE_LOG2));
        qual_d = in_box && (state_q == SOLID || state_q == BLINK_ON);
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q     <= HIDDEN;
            blink_cnt_q <= '0;
            frame_q     <= '0;
            hold_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            show_q      <= 1'b0;
            blink_q     <= 1'b0;
            anim_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            frame_q     <= frame_d;
            hold_q      <= hold_d;
            if (frame_tick_in) begin
                x_q     <= x_in;
                y_q     <= y_in;
                show_q  <= show_in;
                blink_q <= blink_en_in;
                anim_q  <= anim_en_in;
            end
        end
    end

    // Stages: address, image ROM (2), palette ROM (1) + masked output register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            addr_q     <= '0;
            qual_q     <= '0;
            idx_a_q    <= '0;
            idx_q      <= '0;
            idx_p_q    <= '0;
            rgb_a_q    <= '0;
            red_out    <= '0;
            green_out  <= '0;
            blue_out   <= '0;
            opaque_out <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            qual_q  <= {qual_q[2:0], qual_d};
            idx_a_q <= image_rom(addr_q);
            idx_q   <= idx_a_q;
            rgb_a_q <= palette_rom(idx_q);
            idx_p_q <= idx_q;
            if (qual_q[3] && idx_p_q != 8'(TRANSPARENT_IDX)) begin
                {red_out, green_out, blue_out} <= rgb_a_q;
                opaque_out <= 1'b1;
            end else begin
                {red_out, green_out, blue_out} <= '0;
                opaque_out <= 1'b0;
            end
        end
    end

    // Shadow mode bits are kept for visibility of the latched frame configuration.
    logic unused_shadow;
    assign unused_shadow = show_q ^ blink_q ^ anim_q;
endmodule

// File: tb/tb_banner_sprite.sv
// Bench for banner_sprite: fixed vector table, hand sequences for blink/animation/reset/shadowing,
// then randomized traffic checked against a frame-level reference model.
module tb_banner_sprite;
    localparam int W = 73, H = 9, NF = 4, S = 2, FH = 8, BP = 30, T = 0;
    localparam int BOXW = W * (1 << S);
    localparam int BOXH = H * (1 << S);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic [10:0] x_in = '0;
    logic [9:0]  y_in = '0;
    logic        frame_tick = 1'b0, show = 1'b0, blink = 1'b0, anim = 1'b0;
    logic [7:0]  red_out, green_out, blue_out;
    logic        opaque_out;
    logic [1:0]  state_out;

    always #5 clk = ~clk;

    banner_sprite #(
        .WIDTH(W), .HEIGHT(H), .NUM_FRAMES(NF), .SCALE_LOG2(S),
        .FRAME_HOLD(FH), .BLINK_PERIOD(BP), .TRANSPARENT_IDX(T)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst),
        .hcount_in(hcount), .vcount_in(vcount),
        .x_in(x_in), .y_in(y_in),
        .frame_tick_in(frame_tick), .show_in(show),
        .blink_en_in(blink), .anim_en_in(anim),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .opaque_out(opaque_out), .state_out(state_out)
    );

    int errors = 0;
    int checks = 0;
    logic [24:0] exp_q[$];
    string       name_q[$];

    // Reference model: mode 0 hidden, 1 solid, 2 blinking; counts of ticks since entry.
    int m_x, m_y, m_mode, m_bcnt, m_acnt;

    function automatic logic [24:0] model_pix(int h, int v);
        int frame, addr, idx;
        bit vis;
        if (h < m_x || h >= m_x + BOXW || v < m_y || v >= m_y + BOXH) return '0;
        vis = (m_mode == 1) || (m_mode == 2 && ((m_bcnt / BP) % 2 == 0));
        if (!vis) return '0;
        frame = (m_acnt / FH) % NF;
        addr  = frame * W * H + ((v - m_y) / (1 << S)) * W + (h - m_x) / (1 << S);
        idx   = addr % 256;
        if (idx == T) return '0;
        return {1'b1, 8'(idx), 8'(255 - idx), 8'((idx % 16) * 16 + idx / 16)};
    endfunction

    function automatic int model_state();
        if (m_mode == 0) return 0;
        if (m_mode == 1) return 1;
        return ((m_bcnt / BP) % 2 == 0) ? 2 : 3;
    endfunction

    task automatic model_tick(input bit s, input bit b, input bit a, input int x, input int y);
        int prev;
        prev = m_mode;
        m_x  = x;
        m_y  = y;
        if (!s) m_mode = 0;
        else if (!b) m_mode = 1;
        else if (m_mode != 2) begin
            m_mode = 2;
            m_bcnt = 0;
        end else m_bcnt++;
        if (m_mode == 0 && prev != 0) m_acnt = 0;
        else if (a) m_acnt++;
    endtask

    task automatic check_pix(input string nm, input logic [24:0] e);
        logic [24:0] got;
        got = {opaque_out, red_out, green_out, blue_out};
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, e, $time);
        end
    endtask

    task automatic check_state(input string nm, input int e);
        checks++;
        if (state_out !== 2'(e)) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d at %0t", nm, state_out, e, $time);
        end
    endtask

    // One pixel cycle; output for this input is compared five edges later.
    task automatic cyc(input int h, input int v, input bit tk, input bit use_exp,
                       input logic [24:0] ev, input string nm);
        logic [24:0] e;
        string n;
        hcount     = 11'(h);
        vcount     = 10'(v);
        frame_tick = tk;
        e = use_exp ? ev : model_pix(h, v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (tk) model_tick(show, blink, anim, int'(x_in), int'(y_in));
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        if (exp_q.size() == 5) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check_pix(n, e);
        end
    endtask

    task automatic do_reset(input string nm);
        rst        = 1'b1;
        frame_tick = 1'b0;
        @(posedge clk);
        #1;
        check_pix({nm, "_out"}, '0);
        check_state({nm, "_state"}, 0);
        rst = 1'b0;
        m_x = 0; m_y = 0; m_mode = 0; m_bcnt = 0; m_acnt = 0;
        exp_q.delete();
        name_q.delete();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('0);
            name_q.push_back({nm, "_flush"});
        end
    endtask

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic [24:0] exp;
    } vec_t;
    vec_t vecs[12];

    localparam logic [24:0] PIX74  = 25'h14AB5A4;
    localparam logic [24:0] PIX219 = 25'h1DB24BD;
    localparam logic [24:0] PIX108 = 25'h16C93C6;
    localparam logic [24:0] PIX253 = 25'h1FD02DF;

    initial begin
        logic [24:0] anim_exp[5];
        int blink_at[7];
        int blink_st[7];
        int h, v;

        vecs[0]  = '{h: 11'd100, v: 10'd50, exp: 25'h0};        // transparent index at address 0
        vecs[1]  = '{h: 11'd104, v: 10'd54, exp: PIX74};        // address WIDTH+1
        vecs[2]  = '{h: 11'd99,  v: 10'd50, exp: 25'h0};
        vecs[3]  = '{h: 11'd391, v: 10'd85, exp: 25'h1906F09};
        vecs[4]  = '{h: 11'd392, v: 10'd85, exp: 25'h0};
        vecs[5]  = '{h: 11'd391, v: 10'd86, exp: 25'h0};
        vecs[6]  = '{h: 11'd200, v: 10'd60, exp: 25'h1AB54BA};
        vecs[7]  = '{h: 11'd100, v: 10'd49, exp: 25'h0};
        vecs[8]  = '{h: 11'd103, v: 10'd53, exp: 25'h0};
        vecs[9]  = '{h: 11'd108, v: 10'd50, exp: 25'h102FD20};
        vecs[10] = '{h: 11'd100, v: 10'd85, exp: 25'h148B784};
        vecs[11] = '{h: 11'd391, v: 10'd50, exp: 25'h148B784};
        anim_exp = '{PIX219, PIX108, PIX253, PIX74, PIX219};
        blink_at = '{1, 30, 31, 60, 61, 90, 91};
        blink_st = '{2, 2, 3, 3, 2, 2, 3};

        do_reset("reset");
        // Ticks with show low keep the sprite hidden.
        show = 1'b0; x_in = 11'd100; y_in = 10'd50;
        cyc(104, 54, 1, 0, '0, "hidden_tick");
        cyc(104, 54, 0, 1, '0, "hidden_pix");
        check_state("hidden_state", 0);

        show = 1'b1;
        cyc(0, 0, 1, 0, '0, "setup");
        check_state("solid_state", 1);
        for (int i = 0; i < 12; i++)
            cyc(int'(vecs[i].h), int'(vecs[i].v), 0, 1, vecs[i].exp, $sformatf("tbl%0d", i));

        // Placement changes only take effect at the next tick.
        x_in = 11'd300;
        cyc(104, 54, 0, 1, PIX74, "x_no_tick");
        cyc(0, 0, 1, 0, '0, "x_tick");
        cyc(104, 54, 0, 1, '0, "x_old_pos");
        cyc(304, 54, 0, 1, PIX74, "x_new_pos");
        x_in = 11'd100;
        cyc(0, 0, 1, 0, '0, "x_restore");

        blink = 1'b1;
        for (int t = 1; t <= 95; t++) begin
            cyc(200, 60, 1, 0, '0, "blink_tick");
            for (int k = 0; k < 7; k++)
                if (blink_at[k] == t) check_state($sformatf("blink_t%0d", t), blink_st[k]);
            cyc(200, 60, 0, 0, '0, "blink_pix");
        end
        blink = 1'b0;
        cyc(200, 60, 1, 0, '0, "unblink_tick");
        check_state("unblink_state", 1);
        cyc(200, 60, 0, 1, 25'h1AB54BA, "unblink_pix");

        show = 1'b0;
        cyc(0, 0, 1, 0, '0, "anim_hide");
        show = 1'b1; anim = 1'b1;
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < FH; k++) cyc(0, 0, 1, 0, '0, "anim_tick");
            cyc(104, 54, 0, 1, anim_exp[b], $sformatf("anim_blk%0d", b));
        end
        anim = 1'b0;
        for (int k = 0; k < 20; k++) cyc(104, 54, 1, 0, '0, "freeze_tick");
        cyc(104, 54, 0, 1, PIX219, "anim_freeze");
        show = 1'b0;
        cyc(0, 0, 1, 0, '0, "anim_hide2");
        show = 1'b1;
        cyc(0, 0, 1, 0, '0, "anim_show2");
        cyc(104, 54, 0, 1, PIX74, "anim_hidden_reset");

        // Reset while drawing: dark until a tick with show high.
        for (int k = 0; k < 3; k++) cyc(104, 54, 0, 1, PIX74, "pre_reset");
        do_reset("mid_reset");
        for (int k = 0; k < 6; k++) cyc(104, 54, 0, 1, '0, "post_reset_dark");
        show = 1'b0;
        cyc(104, 54, 1, 0, '0, "post_reset_hide_tick");
        for (int k = 0; k < 3; k++) cyc(104, 54, 0, 1, '0, "post_reset_still_dark");
        show = 1'b1;
        cyc(104, 54, 1, 0, '0, "post_reset_show_tick");
        cyc(104, 54, 0, 1, PIX74, "post_reset_visible");

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 15) == 0)
                x_in = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1850, 2047))
                                                   : 11'($urandom_range(0, 300));
            if ($urandom_range(0, 15) == 0)
                y_in = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(980, 1023))
                                                   : 10'($urandom_range(0, 200));
            h = m_x + int'($urandom_range(0, BOXW + 8)) - 4;
            v = m_y + int'($urandom_range(0, BOXH + 6)) - 3;
            if (h < 0) h = 0;
            if (h > 2047) h = 2047;
            if (v < 0) v = 0;
            if (v > 1023) v = 1023;
            if ($urandom_range(0, 7) == 0) begin
                show  = ($urandom_range(0, 4) != 0);
                blink = ($urandom_range(0, 3) == 0);
                anim  = $urandom_range(0, 1);
                cyc(h, v, 1, 0, '0, "rand_tick");
                check_state("rand_state", model_state());
            end else begin
                cyc(h, v, 0, 0, '0, "rand_pix");
            end
        end
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, '0, "drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banner_sprite.md
BANNER_SPRITE -- requirements
Module: banner_sprite

Interface
REQ-001 SHALL have parameter WIDTH, default 73, sprite width in source pixels.
REQ-002 SHALL have parameter HEIGHT, default 9, sprite height in source pixels.
REQ-003 SHALL have parameter NUM_FRAMES, default 4, number of animation images stored back-to-back in image memory.
REQ-004 SHALL have parameter SCALE_LOG2, default 2, integer upscale factor 2^SCALE_LOG2 in both axes.
REQ-005 SHALL have parameter FRAME_HOLD, default 8, video frames each animation image is held.
REQ-006 SHALL have parameter BLINK_PERIOD, default 30, video frames per blink half-period.
REQ-007 SHALL have parameter TRANSPARENT_IDX, default 0, palette index rendered as transparent.
REQ-008 SHALL have ports pixel_clk_in (input, 1, sole clock) and rst_in (input, 1, synchronous active-high reset).
REQ-009 SHALL have ports hcount_in (input, 11), vcount_in (input, 10): current raster position.
REQ-010 SHALL have ports x_in (input, 11), y_in (input, 10): requested top-left corner.
REQ-011 SHALL have ports frame_tick_in (input, 1): one-cycle pulse per video frame, at end of active video.
REQ-012 SHALL have ports show_in (input, 1) enable display, blink_en_in (input, 1) enable blinking, anim_en_in (input, 1) enable frame animation.
REQ-013 SHALL have ports red_out, green_out, blue_out (output, 8 each) and opaque_out (output, 1: pixel drawn and non-transparent).

Function
REQ-014 SHALL latch x_in, y_in, show_in, blink_en_in, anim_en_in into shadow registers only on frame_tick_in; all rendering uses shadow values (tear-free).
REQ-015 SHALL define in-box as x <= hcount_in < x + (WIDTH<<SCALE_LOG2) and y <= vcount_in < y + (HEIGHT<<SCALE_LOG2), compared at 12 bits (no wrap past 2047/1023; box clipped at those limits).
REQ-016 SHALL compute col = (hcount_in - x) >> SCALE_LOG2, row = (vcount_in - y) >> SCALE_LOG2, address = frame_idx*WIDTH*HEIGHT + row*WIDTH + col, width $clog2(NUM_FRAMES*WIDTH*HEIGHT), registered in stage 1.
REQ-017 SHALL read 8-bit palette index from a 2-cycle-latency image ROM, then 24-bit RGB from a 2-cycle-latency 256-entry palette ROM.
REQ-018 SHALL have fixed latency 5 cycles from hcount_in/vcount_in to registered RGB/opaque_out; draw qualifier delayed through a matching 5-stage pipe.
REQ-019 SHALL drive RGB = 0 and opaque_out = 0 when qualifier low or palette index == TRANSPARENT_IDX (index pipelined alongside palette read).
REQ-020 SHALL implement display FSM states HIDDEN, SOLID, BLINK_ON, BLINK_OFF, advancing only on frame_tick_in.
REQ-021 SHALL transition: shadow show=0 -> HIDDEN from any state; show=1, blink=0 -> SOLID; show=1, blink=1 from HIDDEN/SOLID -> BLINK_ON with blink counter cleared.
REQ-022 SHALL in BLINK_ON/BLINK_OFF count ticks; at BLINK_PERIOD-1 toggle state and clear counter.
REQ-023 SHALL set qualifier = in-box AND state in {SOLID, BLINK_ON}.
REQ-024 SHALL advance frame_idx every FRAME_HOLD ticks while shadow anim=1, wrapping NUM_FRAMES-1 -> 0; anim=0 holds frame_idx and hold counter.
REQ-025 SHALL reset frame_idx and hold counter to 0 on entry to HIDDEN.
REQ-026 SHALL, with NUM_FRAMES=1, keep frame_idx = 0 permanently.

Reset
REQ-027 SHALL on rst_in: FSM = HIDDEN, frame_idx, hold and blink counters = 0, shadow registers = 0, pipeline qualifiers = 0, RGB = 0, opaque_out = 0 on the next edge.
REQ-028 SHALL treat rst_in asserted mid-pixel or mid-frame identically; outputs remain 0 until a frame_tick_in with show_in=1 after release.

Verification
REQ-029 Reset mid-render, SOLID state -> RGB/opaque_out 0 from next edge; stay 0 until frame_tick_in with show_in=1.
REQ-030 show=1, x=100, y=50, SCALE_LOG2=2, tick -> hcount 100..391, vcount 50..85 draw; hcount 99 and 392 black; output 5 cycles after input.
REQ-031 Pixel (h=104,v=54) -> address WIDTH+1 read; palette index TRANSPARENT_IDX at any address -> opaque_out=0, RGB=0.
REQ-032 blink=1, BLINK_PERIOD=30 -> visible ticks 1-30, blank 31-60, visible 61-90; blink=0 -> SOLID on next tick.
REQ-033 anim=1, FRAME_HOLD=8, NUM_FRAMES=4 -> frame_idx 0,1,2,3,0 every 8 ticks; anim=0 freezes; show=0 resets to 0.
REQ-034 x_in changed mid-frame without tick -> rendered position unchanged until next frame_tick_in.
